led_blink_sequencer: RTL and testbench

LED_BLINK_SEQUENCER -- requirements
Module: led_blink_sequencer

---
 rtl/led_blink_sequencer_if.sv | 33 +++
 rtl/led_blink_sequencer.sv | 150 +++++++++++++++
 tb/tb_led_blink_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_sequencer_if.sv
// Control/status bundle for led_blink_sequencer.
// LED_BLINK_SEQUENCER_PAUSE_EN adds the pause input.
interface led_blink_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 stop;
  logic [CNT_WIDTH-1:0] on_time;
  logic [CNT_WIDTH-1:0] off_time;
  logic [7:0]           repeat_count;
`ifdef LED_BLINK_SEQUENCER_PAUSE_EN
  logic                 pause;
`endif
  logic                 led;
  logic                 busy;
  logic                 done;

  modport master (
    output start, stop, on_time, off_time, repeat_count,
    input  led, busy, done
`ifdef LED_BLINK_SEQUENCER_PAUSE_EN
    , output pause
`endif
  );

  modport slave (
    input  start, stop, on_time, off_time, repeat_count,
    output led, busy, done
`ifdef LED_BLINK_SEQUENCER_PAUSE_EN
    , input pause
`endif
  );
endinterface

// File: rtl/led_blink_sequencer.sv
// Tick-timed LED on/off sequencer with repeat count, stop abort and done pulse.
// Optional pause freeze when LED_BLINK_SEQUENCER_PAUSE_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start, led off, not busy
// ON     | led lit for on_time ticks
// OFF    | led dark for off_time ticks, cycle count bumps at end
// DONE   | one-cycle done pulse, then back to IDLE
module led_blink_sequencer #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int TICK_FREQ  = 1_000,
  parameter int CNT_WIDTH  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  led_blink_sequencer_if.slave  bus
);
  localparam int PRESCALE = CLOCK_FREQ / TICK_FREQ;
  localparam int PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("led_blink_sequencer: CLOCK_FREQ/TICK_FREQ must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  state_t               state_q;
  logic [PW-1:0]        presc_q;
  logic [CNT_WIDTH-1:0] phase_q;
  logic [CNT_WIDTH-1:0] on_q;
  logic [CNT_WIDTH-1:0] off_q;
  logic [7:0]           rep_q;
  logic [7:0]           cyc_q;
  logic                 led_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 tick;
  logic                 run;
  logic [7:0]           cyc_inc;

  assign tick    = (presc_q == PRESC_LAST);
  assign cyc_inc = cyc_q + 8'd1;

`ifdef LED_BLINK_SEQUENCER_PAUSE_EN
  assign run = ~bus.pause;
`else
  assign run = 1'b1;
`endif

  // Phase counter counts down to zero; a zero duration behaves as one tick.
  function automatic logic [CNT_WIDTH-1:0] phase_load(input logic [CNT_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      phase_q <= '0;
      on_q    <= '0;
      off_q   <= '0;
      rep_q   <= '0;
      cyc_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.stop) begin
            on_q    <= bus.on_time;
            off_q   <= bus.off_time;
            rep_q   <= bus.repeat_count;
            cyc_q   <= '0;
            presc_q <= '0;
            phase_q <= phase_load(bus.on_time);
            state_q <= S_ON;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ON: begin
          if (bus.stop) begin
            state_q <= S_IDLE;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (run) begin
            if (tick) begin
              presc_q <= '0;
              if (phase_q == '0) begin
                state_q <= S_OFF;
                phase_q <= phase_load(off_q);
                led_q   <= 1'b0;
              end else begin
                phase_q <= phase_q - CNT_WIDTH'(1);
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
        end
        S_OFF: begin
          if (bus.stop) begin
            state_q <= S_IDLE;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (run) begin
            if (tick) begin
              presc_q <= '0;
              if (phase_q == '0) begin
                cyc_q <= cyc_inc;
                if (rep_q != 8'd0 && cyc_inc == rep_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_ON;
                  phase_q <= phase_load(on_q);
                  led_q   <= 1'b1;
                end
              end else begin
                phase_q <= phase_q - CNT_WIDTH'(1);
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          led_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_led_blink_sequencer.sv
// Self-checking bench for led_blink_sequencer at PRESCALE=4.
module tb_led_blink_sequencer;
  localparam int PS = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  led_blink_sequencer_if #(.CNT_WIDTH(16)) bus();

  led_blink_sequencer #(
    .CLOCK_FREQ(1000),
    .TICK_FREQ (250),
    .CNT_WIDTH (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int on_t;
    int off_t;
    int rep;
    int restart_at;
    int restart_on;
    int exp_high;
    int exp_busy;
    int exp_done;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Start a sequence and measure first ON length, busy length and done pulses.
  task automatic run_measure(input int on_t, input int off_t, input int rep,
                             input int restart_at, input int restart_on,
                             output int first_high, output int busy_cnt,
                             output int done_cnt, output bit timeout);
    bit still_high;
    @(negedge clk);
    bus.on_time      = 16'(on_t);
    bus.off_time     = 16'(off_t);
    bus.repeat_count = 8'(rep);
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    first_high = 0;
    busy_cnt   = 0;
    done_cnt   = 0;
    timeout    = 1'b1;
    still_high = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (!bus.busy) begin
        timeout = 1'b0;
        break;
      end
      busy_cnt++;
      if (bus.done) done_cnt++;
      if (still_high && bus.led) first_high++;
      else still_high = 1'b0;
      if (i == restart_at) begin
        bus.start   = 1'b1;
        bus.on_time = 16'(restart_on);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  // Reference: expected per-cycle {led,busy,done} built from the phase durations.
  task automatic check_trace(input int on_t, input int off_t, input int rep);
    logic [2:0] exp_q[$];
    int on_c;
    int off_c;
    int prints;
    on_c   = ((on_t == 0) ? 1 : on_t) * PS;
    off_c  = ((off_t == 0) ? 1 : off_t) * PS;
    prints = 0;
    for (int r = 0; r < rep; r++) begin
      for (int k = 0; k < on_c; k++)  exp_q.push_back(3'b110);
      for (int k = 0; k < off_c; k++) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b000);
    @(negedge clk);
    bus.on_time      = 16'(on_t);
    bus.off_time     = 16'(off_t);
    bus.repeat_count = 8'(rep);
    bus.start        = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clk);
      bus.start = 1'b0;
      total++;
      if ({bus.led, bus.busy, bus.done} != exp_q[i]) begin
        bad++;
        if (prints < 4) begin
          prints++;
          $display("FAIL trace on=%0d off=%0d rep=%0d cyc=%0d: actual=%b required=%b",
                   on_t, off_t, rep, i, {bus.led, bus.busy, bus.done}, exp_q[i]);
        end
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    int  fh, bc, dc;
    bit  to;
    int  rises, dones, busy_low;
    bit  prev_led;

    total = 0;
    bad   = 0;
    vecs[0] = '{2, 3, 2, -1, 0,  8, 41, 1};
    vecs[1] = '{0, 0, 1, -1, 0,  4,  9, 1};
    vecs[2] = '{1, 2, 3, -1, 0,  4, 37, 1};
    vecs[3] = '{5, 1, 1, -1, 0, 20, 25, 1};
    vecs[4] = '{3, 0, 2, -1, 0, 12, 33, 1};
    vecs[5] = '{2, 3, 1,  3, 7,  8, 21, 1};

    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.on_time      = '0;
    bus.off_time     = '0;
    bus.repeat_count = '0;
`ifdef LED_BLINK_SEQUENCER_PAUSE_EN
    bus.pause        = 1'b0;
`endif
    #2;
    check("reset_led",  int'(bus.led),  0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      run_measure(vecs[v].on_t, vecs[v].off_t, vecs[v].rep,
                  vecs[v].restart_at, vecs[v].restart_on, fh, bc, dc, to);
      check($sformatf("vec%0d_timeout", v), int'(to), 0);
      check($sformatf("vec%0d_first_on", v), fh, vecs[v].exp_high);
      check($sformatf("vec%0d_busy_len", v), bc, vecs[v].exp_busy);
      check($sformatf("vec%0d_done_cnt", v), dc, vecs[v].exp_done);
      repeat (2) @(negedge clk);
    end

    for (int n = 0; n < 8; n++)
      check_trace(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(1, 3)));

    // Endless run with 0/0 durations: cycle counter wraps past 255 and keeps going.
    @(negedge clk);
    bus.on_time      = 16'd0;
    bus.off_time     = 16'd0;
    bus.repeat_count = 8'd0;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rises    = 0;
    dones    = 0;
    busy_low = 0;
    prev_led = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      if (bus.led && !prev_led) rises++;
      if (bus.done) dones++;
      if (!bus.busy) busy_low++;
      prev_led = bus.led;
      @(negedge clk);
    end
    check("endless_busy_low", busy_low, 0);
    check("endless_done",     dones,    0);
    check("endless_rises",    int'(rises >= 262), 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_led",  int'(bus.led),  0);
    check("stop_busy", int'(bus.busy), 0);
    check("stop_done", int'(bus.done), 0);

    // start and stop together in IDLE: stop wins.
    @(negedge clk);
    bus.on_time      = 16'd2;
    bus.repeat_count = 8'd1;
    bus.start        = 1'b1;
    bus.stop         = 1'b1;
    busy_low = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (bus.busy || bus.led) busy_low++;
    end
    check("start_stop_idle", busy_low, 0);

    // Asynchronous reset in the middle of ON.
    @(negedge clk);
    bus.on_time      = 16'd5;
    bus.off_time     = 16'd1;
    bus.repeat_count = 8'd1;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_led", int'(bus.led), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led",  int'(bus.led),  0);
    check("async_reset_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy || bus.led || bus.done) busy_low++;
    end
    check("post_reset_quiet", busy_low, 0);

`ifdef LED_BLINK_SEQUENCER_PAUSE_EN
    @(negedge clk);
    bus.on_time      = 16'd2;
    bus.off_time     = 16'd1;
    bus.repeat_count = 8'd1;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    fh = 0;
    for (int i = 0; i < 200 && bus.led; i++) begin
      fh++;
      bus.pause = (i >= 3 && i < 13);
      @(negedge clk);
    end
    bus.pause = 1'b0;
    check("pause_on_len", fh, 18);
    repeat (10) @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
